// File: rtl/cpld_ramdisk_if.sv
// CPU bus, mapper request and SRAM strobe bundle shared by the RAM-disk sequencer.
// The CPU data bus is bidirectional and stays a plain inout port on the block.
interface cpld_ramdisk_if #(
    parameter int ADDR_W = 19
);
    logic [15:0]       adr;
    logic              iorq_b;
    logic              m1_b;
    logic              rd_b;
    logic              wr_b;
    logic              map_ramcs_b;
    logic [4:0]        map_adrhi;
    logic              ramrd_b;
    logic [ADDR_W-1:0] sram_adr;
    logic              sram_ce_b;
    logic              sram_oe_b;
    logic              sram_we_b;

    modport master (
        output adr, iorq_b, m1_b, rd_b, wr_b, map_ramcs_b, map_adrhi, ramrd_b,
        input  sram_adr, sram_ce_b, sram_oe_b, sram_we_b
    );

    modport slave (
        input  adr, iorq_b, m1_b, rd_b, wr_b, map_ramcs_b, map_adrhi, ramrd_b,
        output sram_adr, sram_ce_b, sram_oe_b, sram_we_b
    );
endinterface

// File: rtl/cpld_ramdisk_ctrl.sv
// Shares the expansion SRAM between the bank mapper and an IO-mapped RAM-disk port
// (pointer registers plus an auto-incrementing data port at register 3).
module cpld_ramdisk_ctrl #(
    parameter int         ADDR_W  = 19,
    parameter logic [7:0] PORT_HI = 8'hFE
) (
    input  logic           clk,
    input  logic           reset_b,
    cpld_ramdisk_if.slave  bus,
    inout  wire  [7:0]     data
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_nx;
    logic [1:0]        rsel;
    logic              dir_wr;
    logic              first;
    logic              autoinc;
    logic              coll;
    logic              coll_acc;
    logic [ADDR_W-1:0] ptr;
    logic [21:0]       ptr_ext;
    logic              hit, io_cyc, io_sram, drive;
    logic [7:0]        reg_q;
    logic [ADDR_W-1:0] s_adr;
    logic              s_ce_b, s_oe_b, s_we_b;

    assign hit     = bus.adr[15:8] == PORT_HI;
    // M1 low with IORQ low is an interrupt acknowledge, never a port access
    assign io_cyc  = !bus.iorq_b && bus.m1_b && hit && (!bus.rd_b || !bus.wr_b);
    assign ptr_ext = 22'(ptr);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (io_cyc) state_nx = ACCESS;
            ACCESS:  if (bus.iorq_b) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rsel     <= 2'd0;
            dir_wr   <= 1'b0;
            first    <= 1'b0;
            autoinc  <= 1'b1;
            coll     <= 1'b0;
            coll_acc <= 1'b0;
            ptr      <= '0;
        end else begin
            case (state)
                IDLE: if (io_cyc) begin
                    rsel     <= bus.adr[1:0];
                    dir_wr   <= !bus.wr_b;
                    first    <= 1'b1;
                    coll_acc <= 1'b0;
                end
                ACCESS: begin
                    first <= 1'b0;
                    if (first && dir_wr) begin
                        case (rsel)
                            2'd0: ptr <= ADDR_W'({ptr_ext[21:8], data});
                            2'd1: ptr <= ADDR_W'({ptr_ext[21:16], data, ptr_ext[7:0]});
                            2'd2: begin
                                ptr     <= ADDR_W'({3'b000, data[2:0], ptr_ext[15:0]});
                                autoinc <= data[7];
                                coll    <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                    // a mapper cycle landing mid-access steals the SRAM; flag it and skip the increment
                    if (!bus.map_ramcs_b) begin
                        coll     <= 1'b1;
                        coll_acc <= 1'b1;
                    end
                end
                DONE: if (rsel == 2'd3 && autoinc && !coll_acc) ptr <= ptr + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        case (rsel)
            2'd0:    reg_q = ptr_ext[7:0];
            2'd1:    reg_q = ptr_ext[15:8];
            2'd2:    reg_q = {autoinc, coll, ptr_ext[21:16]};
            default: reg_q = 8'h00;
        endcase
    end

    assign io_sram = (state == ACCESS) && (rsel == 2'd3) && bus.map_ramcs_b;
    assign drive   = reset_b && (state == ACCESS) && (rsel != 2'd3) && !dir_wr
                     && !bus.iorq_b && !bus.rd_b;

    always_comb begin
        s_adr  = ADDR_W'({bus.map_adrhi, bus.adr[13:0]});
        s_ce_b = bus.map_ramcs_b;
        s_oe_b = bus.ramrd_b;
        s_we_b = bus.wr_b;
        if (io_sram) begin
            s_adr  = ptr;
            s_ce_b = bus.iorq_b;
            s_oe_b = dir_wr  || bus.iorq_b || bus.rd_b;
            s_we_b = !dir_wr || bus.iorq_b || bus.wr_b;
        end
        if (!reset_b) begin
            s_ce_b = 1'b1;
            s_oe_b = 1'b1;
            s_we_b = 1'b1;
        end
    end

    assign bus.sram_adr  = s_adr;
    assign bus.sram_ce_b = s_ce_b;
    assign bus.sram_oe_b = s_oe_b;
    assign bus.sram_we_b = s_we_b;
    assign data          = drive ? reg_q : 8'bz;
endmodule

// File: tb/tb_cpld_ramdisk_ctrl.sv
// Bench for cpld_ramdisk_ctrl: table of Z80 IO cycles, SRAM write scoreboard, and
// hand sequences for int ack, mapper path, collision and reset mid-access.
module tb_cpld_ramdisk_ctrl;
    logic        clk = 1'b0;
    logic        reset_b;
    logic        tb_oe;
    logic [7:0]  tb_dout;
    wire  [7:0]  data;
    logic [7:0]  mem [0:524287];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    cpld_ramdisk_if #(.ADDR_W(19)) bus ();

    cpld_ramdisk_ctrl #(.ADDR_W(19), .PORT_HI(8'hFE)) dut (
        .clk(clk), .reset_b(reset_b), .bus(bus), .data(data)
    );

    wire sram_drv = !bus.sram_ce_b && !bus.sram_oe_b;
    assign data = tb_oe ? tb_dout : (sram_drv ? mem[bus.sram_adr] : 8'bz);

    typedef struct packed { logic [18:0] a; logic [7:0] d; } wr_t;
    typedef struct { bit wr; logic [15:0] port; logic [7:0] d; logic [7:0] exp; } vec_t;

    wr_t         exp_q [$];
    vec_t        vecs [$];
    logic [18:0] m_ptr;
    bit          m_inc;
    bit          we_act = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endfunction

    // SRAM model + write scoreboard: each we_b pulse pops one expected write
    always @(negedge clk) begin
        if (!bus.sram_we_b && !bus.sram_ce_b) begin
            if (!we_act) begin
                we_act = 1'b1;
                mem[bus.sram_adr] = data;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected: got adr %h dat %h want no write", bus.sram_adr, data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_adr", 32'(bus.sram_adr), 32'(e.a));
                    chk("wr_dat", 32'(data), 32'(e.d));
                end
            end
        end else we_act = 1'b0;
    end

    function automatic void model_wr(logic [15:0] p, logic [7:0] d);
        if (p[15:8] != 8'hFE) return;
        case (p[1:0])
            2'd0: m_ptr[7:0]   = d;
            2'd1: m_ptr[15:8]  = d;
            2'd2: begin m_ptr[18:16] = d[2:0]; m_inc = d[7]; end
            default: begin
                exp_q.push_back({m_ptr, d});
                if (m_inc) m_ptr = m_ptr + 19'd1;
            end
        endcase
    endfunction

    task automatic io_wr(input logic [15:0] p, input logic [7:0] d);
        model_wr(p, d);
        @(posedge clk); #2;
        bus.adr = p; bus.iorq_b = 1'b0; bus.wr_b = 1'b0; tb_oe = 1'b1; tb_dout = d;
        repeat (3) @(posedge clk);
        #2;
        bus.iorq_b = 1'b1; bus.wr_b = 1'b1; tb_oe = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic io_rd(input logic [15:0] p, output logic [7:0] v, output bit oe_lo, output bit drv);
        oe_lo = 1'b0; drv = 1'b0;
        @(posedge clk); #2;
        bus.adr = p; bus.iorq_b = 1'b0; bus.rd_b = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (!bus.sram_oe_b && !bus.sram_ce_b) oe_lo = 1'b1;
            if (dut.drive) drv = 1'b1;
            v = data;
        end
        @(posedge clk); #2;
        bus.iorq_b = 1'b1; bus.rd_b = 1'b1;
        repeat (2) @(posedge clk);
        if (p[15:8] == 8'hFE && p[1:0] == 2'd3 && m_inc) m_ptr = m_ptr + 19'd1;
    endtask

    task automatic rd_chk(input logic [15:0] p, input logic [7:0] exp, input string nm);
        logic [7:0] v; bit o, d;
        io_rd(p, v, o, d);
        chk(nm, 32'(v), 32'(exp));
    endtask

    function automatic void add(bit wr, logic [15:0] p, logic [7:0] d, logic [7:0] exp);
        vec_t t;
        t.wr = wr; t.port = p; t.d = d; t.exp = exp;
        vecs.push_back(t);
    endfunction

    initial begin
        logic [7:0] v;
        bit o, dr, bad;
        reset_b = 1'b0; tb_oe = 1'b0; tb_dout = 8'h00;
        bus.adr = 16'h0000; bus.iorq_b = 1'b1; bus.m1_b = 1'b1; bus.rd_b = 1'b1; bus.wr_b = 1'b1;
        bus.map_ramcs_b = 1'b1; bus.map_adrhi = 5'h00; bus.ramrd_b = 1'b1;
        m_ptr = '0; m_inc = 1'b1;

        add(1, 16'hFE00, 8'h45, 0); add(1, 16'hFE01, 8'h23, 0); add(1, 16'hFE02, 8'h81, 0);
        add(0, 16'hFE02, 0, 8'h81); add(0, 16'hFE00, 0, 8'h45); add(0, 16'hFE01, 0, 8'h23);
        add(1, 16'hFE03, 8'hA5, 0); add(0, 16'hFE00, 0, 8'h46);
        add(1, 16'hFE00, 8'h45, 0); add(0, 16'hFE03, 0, 8'hA5); add(0, 16'hFE00, 0, 8'h46);
        add(1, 16'hFD03, 8'h5A, 0); add(0, 16'hFE00, 0, 8'h46);
        add(1, 16'hFE00, 8'hFF, 0); add(1, 16'hFE01, 8'hFF, 0); add(1, 16'hFE02, 8'h87, 0);
        add(1, 16'hFE03, 8'h00, 0);
        add(0, 16'hFE00, 0, 8'h00); add(0, 16'hFE01, 0, 8'h00); add(0, 16'hFE02, 0, 8'h80);
        add(1, 16'hFE02, 8'h00, 0);
        add(1, 16'hFE03, 8'h11, 0); add(1, 16'hFE03, 8'h22, 0); add(1, 16'hFE03, 8'h33, 0);
        add(0, 16'hFE00, 0, 8'h00); add(0, 16'hFE02, 0, 8'h00);

        #1;
        chk("rst_ce", 32'(bus.sram_ce_b), 1); chk("rst_oe", 32'(bus.sram_oe_b), 1);
        chk("rst_we", 32'(bus.sram_we_b), 1); chk("rst_drive", 32'(dut.drive), 0);
        repeat (2) @(posedge clk);
        #2 reset_b = 1'b1;
        rd_chk(16'hFE02, 8'h80, "rst_reg2");

        foreach (vecs[i]) begin
            if (vecs[i].wr) io_wr(vecs[i].port, vecs[i].d);
            else begin
                io_rd(vecs[i].port, v, o, dr);
                chk($sformatf("vec%0d_rd", i), 32'(v), 32'(vecs[i].exp));
                if (vecs[i].port[1:0] == 2'd3) begin
                    chk($sformatf("vec%0d_oe", i), 32'(o), 1);
                    chk($sformatf("vec%0d_nodrv", i), 32'(dr), 0);
                end
            end
        end

        // interrupt acknowledge with RD also low must not touch the block
        @(posedge clk); #2;
        bus.adr = 16'hFE03; bus.iorq_b = 1'b0; bus.m1_b = 1'b0; bus.rd_b = 1'b0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (!bus.sram_ce_b || !bus.sram_oe_b || dut.drive) bad = 1'b1;
        end
        @(posedge clk); #2;
        bus.iorq_b = 1'b1; bus.m1_b = 1'b1; bus.rd_b = 1'b1;
        repeat (2) @(posedge clk);
        chk("intack_strobe", 32'(bad), 0);
        rd_chk(16'hFE00, 8'h00, "intack_ptr");

        // mapper memory cycle while idle
        @(posedge clk); #2;
        bus.map_ramcs_b = 1'b0; bus.map_adrhi = 5'h1B; bus.adr = 16'h4123; bus.ramrd_b = 1'b0;
        @(negedge clk);
        chk("map_adr", 32'(bus.sram_adr), 32'h6C123);
        chk("map_ce", 32'(bus.sram_ce_b), 0);
        chk("map_oe", 32'(bus.sram_oe_b), 0);
        @(posedge clk); #2;
        bus.map_ramcs_b = 1'b1; bus.ramrd_b = 1'b1;
        rd_chk(16'hFE00, 8'h00, "map_ptr");

        // collision: mapper takes the SRAM during an IO data-port read
        io_wr(16'hFE02, 8'h80);
        io_wr(16'hFE00, 8'h10);
        @(posedge clk); #2;
        bus.adr = 16'hFE03; bus.iorq_b = 1'b0; bus.rd_b = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("coll_io_oe", 32'(bus.sram_oe_b), 0);
        chk("coll_io_adr", 32'(bus.sram_adr), 32'h00010);
        @(posedge clk); #2;
        bus.map_ramcs_b = 1'b0; bus.map_adrhi = 5'h02;
        @(negedge clk);
        chk("coll_map_adr", 32'(bus.sram_adr), 32'h0BE03);
        chk("coll_map_oe", 32'(bus.sram_oe_b), 1);
        @(posedge clk); #2;
        bus.iorq_b = 1'b1; bus.rd_b = 1'b1; bus.map_ramcs_b = 1'b1;
        repeat (2) @(posedge clk);
        rd_chk(16'hFE02, 8'hC0, "coll_flag");
        rd_chk(16'hFE00, 8'h10, "coll_noinc");
        io_wr(16'hFE02, 8'h80);
        rd_chk(16'hFE02, 8'h80, "coll_clear");

        // reset during an IO write to the data port
        io_wr(16'hFE00, 8'h77);
        @(posedge clk); #2;
        bus.adr = 16'hFE03; bus.iorq_b = 1'b0; bus.wr_b = 1'b0; tb_oe = 1'b1; tb_dout = 8'h99;
        @(posedge clk); #1;
        chk("rmid_we_pre", 32'(bus.sram_we_b), 0);
        reset_b = 1'b0;
        #1;
        chk("rmid_ce", 32'(bus.sram_ce_b), 1); chk("rmid_oe", 32'(bus.sram_oe_b), 1);
        chk("rmid_we", 32'(bus.sram_we_b), 1);
        @(posedge clk); #2;
        bus.iorq_b = 1'b1; bus.wr_b = 1'b1; tb_oe = 1'b0;
        reset_b = 1'b1;
        m_ptr = '0; m_inc = 1'b1;
        rd_chk(16'hFE00, 8'h00, "rmid_ptr0");
        rd_chk(16'hFE01, 8'h00, "rmid_ptr1");
        rd_chk(16'hFE02, 8'h80, "rmid_reg2");

        repeat (2) @(posedge clk);
        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
